joy2quad_multi: RTL and testbench
=================================

Name:
joy2quad_multi

Overview:
- Multi-channel digital-to-quadrature encoder. Converts left/right digital controls (keyboard, joystick) into 2-bit quadrature pairs that emulate rotary paddle encoders for arcade cores.
- Successor to the single-channel fixed-rate converter. Adds:
  - a parametrised channel count;
  - a runtime step period;
  - optional hold-to-accelerate;
  - per-step pulse and direction outputs for debug and lamps.
- Sits in the emu top level between input decode and the core's encoder inputs.

Parameters:
- CHANNELS, 2, number of independent encoder channels.
- DIV_W, 16, width of the clkdiv period input and of the per-channel period counter.
- ACCEL_STEPS, 8, consecutive same-direction steps needed before the acceleration level rises by 1.
- ACCEL_MAX, 3, maximum acceleration level; effective period = clkdiv >> level.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- clkdiv  in  DIV_W  base step period in CLK cycles; 0 is treated as 1.
- accel_en  in  1  1 = acceleration enabled; 0 = level held at 0.
- right  in  CHANNELS  per-channel right request, active high, already synchronous to CLK.
- left  in  CHANNELS  per-channel left request, active high.
- steer  out  2*CHANNELS  quadrature for channel i on bits [2i+1:2i]; bit 2i+1 = A, bit 2i = B.
- step_pulse  out  CHANNELS  one-cycle high on each cycle in which that channel's steer changed.
- dir  out  CHANNELS  direction of the most recent step: 1 = right, 0 = left.

Behaviour:
- Reset (Reset_n=0 at an edge):
  - steer = 0, step_pulse = 0, dir = 0.
  - Every channel goes to IDLE with counter = 0, level = 0, step count = 0.
  - Reset overrides all other activity, including mid-run.
- Request decode per channel:
  - right & ~left gives +1.
  - left & ~right gives -1.
  - Neither, or both, gives NONE.
- Phase sequence (AB):
  - +1 advances 00 -> 01 -> 11 -> 10 -> 00.
  - -1 traverses the same sequence in reverse.
  - Wrap-around is continuous.
- Channels are fully independent. No shared state except clkdiv and accel_en.
- State machine per channel: IDLE, RUN.
- IDLE:
  - On NONE: stay in IDLE; steer held.
  - On +1 or -1 sampled at edge k: step at edge k (steer, dir and step_pulse visible from cycle k+1).
  - Load counter = P-1, set step count = 1, level = 0, enter RUN.
- RUN, same direction as last step:
  - If counter != 0: decrement.
  - If counter == 0: step, increment step count, then reload counter = P-1.
  - If the incremented step count == ACCEL_STEPS and accel_en = 1 and level < ACCEL_MAX: level++, step count = 0. This reload already uses the new level.
  - If the level is saturated: step count stays cleared and the level does not change.
- RUN, reversed direction:
  - Step immediately in the new direction at that edge.
  - level = 0, step count = 1, counter = clkdiv_eff-1.
- RUN, NONE: return to IDLE. level = 0, counter = 0; steer and dir held.
- Effective period: P = max(clkdiv_eff >> level, 1), where clkdiv_eff = max(clkdiv, 1). The interval between consecutive steps is exactly P cycles.
- Input changes mid-run:
  - accel_en = 0: level is forced to 0 at the next edge. The current countdown is unaffected; the next reload uses level 0.
  - clkdiv change: takes effect at the next reload only.
- step_pulse: high for exactly the cycle after each stepping edge; otherwise 0.
- Latency: a request at edge k is visible on steer at cycle k+1. There is no input synchronisation inside this block.

Test Plan:
1. Reset: hold Reset_n=0 for 3 cycles with right=all-ones -> steer=0, step_pulse=0, dir=0 throughout. After release, the first step occurs at the first edge with Reset_n=1.
2. clkdiv=4, accel_en=0, right[0] held for 20 edges from edge 0 -> ch0 steps at edges 0,4,8,12,16 with steer[1:0]=01,11,10,00,01 and dir[0]=1; ch1 steer stays 00 with no pulses.
3. Acceleration: ACCEL_STEPS=2, ACCEL_MAX=2, clkdiv=16, accel_en=1, left[0] held -> step intervals 16,8,8,4,4,4… and steer[1:0] walks 10,11,01,00,10…. Dropping accel_en mid-run -> the interval after the next reload returns to 16.
4. Conflict and idle: left[0]=right[0]=1 for 30 cycles -> no steps. Releasing to NONE mid-run -> steer holds its value. A re-press -> immediate step, level back to 0.
5. Reversal at level 2 (clkdiv=16): switch right->left -> step backward at that edge, dir=0, next interval 16.
6. clkdiv=0, right[1] held -> ch1 steps every cycle (00,01,11,10,00…). Assert Reset_n=0 mid-run -> steer=0 at the next cycle.

Source files
------------

// File: rtl/joy2quad_multi.sv
// rtl/joy2quad_multi.sv - multi-channel left/right to quadrature encoder with hold-to-accelerate
module joy2quad_multi #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 16,
  parameter int ACCEL_STEPS = 8,
  parameter int ACCEL_MAX   = 3
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic                  accel_en,
  input  logic [CHANNELS-1:0]   right,
  input  logic [CHANNELS-1:0]   left,
  output logic [2*CHANNELS-1:0] steer,
  output logic [CHANNELS-1:0]   step_pulse,
  output logic [CHANNELS-1:0]   dir
);

  localparam int LVL_W = (ACCEL_MAX < 1) ? 1 : $clog2(ACCEL_MAX + 1);
  localparam int CNT_W = (ACCEL_STEPS < 1) ? 1 : $clog2(ACCEL_STEPS + 1);
  localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(ACCEL_MAX);
  localparam logic [CNT_W:0]   CNT_TOP = (CNT_W + 1)'(ACCEL_STEPS);

  typedef enum logic {IDLE, RUN} state_t;

  // A programmed period of 0 behaves as 1 so the channel never stalls.
  logic [DIV_W-1:0] div_eff;
  assign div_eff = (clkdiv == '0) ? DIV_W'(1) : clkdiv;

  // Countdown reload value for a given acceleration level: max(eff >> lvl, 1) - 1.
  function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] eff,
                                                  input logic [LVL_W-1:0] lvl);
    logic [DIV_W-1:0] p;
    p = eff >> lvl;
    if (p == '0) p = DIV_W'(1);
    return p - DIV_W'(1);
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [DIV_W-1:0] ctr_q, ctr_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             pulse_q, pulse_d;
    logic             fwd, back;

    assign fwd  = right[i] & ~left[i];
    assign back = left[i] & ~right[i];

    // Phase index 0..3 maps onto AB = 00,01,11,10 (Gray order).
    assign steer[2*i+1]  = pos_q[1];
    assign steer[2*i]    = pos_q[1] ^ pos_q[0];
    assign step_pulse[i] = pulse_q;
    assign dir[i]        = dir_q;

    // Next-state logic: decode request, run countdown, step and manage acceleration.
    always_comb begin
      logic [CNT_W:0] cnt_inc;
      state_d = state_q;
      ctr_d   = ctr_q;
      lvl_d   = lvl_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      dir_d   = dir_q;
      pulse_d = 1'b0;
      cnt_inc = {1'b0, cnt_q} + 1'b1;
      case (state_q)
        IDLE: begin
          if (fwd | back) begin
            pos_d   = fwd ? pos_q + 2'd1 : pos_q - 2'd1;
            dir_d   = fwd;
            pulse_d = 1'b1;
            state_d = RUN;
            ctr_d   = reload_val(div_eff, '0);
            cnt_d   = CNT_W'(1);
            lvl_d   = '0;
          end
        end
        RUN: begin
          if (!(fwd | back)) begin
            state_d = IDLE;
            lvl_d   = '0;
            ctr_d   = '0;
            cnt_d   = '0;
          end else if (fwd != dir_q) begin
            // Reversal steps at once and restarts from the base rate.
            pos_d   = fwd ? pos_q + 2'd1 : pos_q - 2'd1;
            dir_d   = fwd;
            pulse_d = 1'b1;
            lvl_d   = '0;
            cnt_d   = CNT_W'(1);
            ctr_d   = reload_val(div_eff, '0);
          end else if (ctr_q != '0) begin
            ctr_d = ctr_q - DIV_W'(1);
            lvl_d = accel_en ? lvl_q : '0;
          end else begin
            pos_d   = fwd ? pos_q + 2'd1 : pos_q - 2'd1;
            dir_d   = fwd;
            pulse_d = 1'b1;
            lvl_d   = accel_en ? lvl_q : '0;
            if (cnt_inc >= CNT_TOP) begin
              cnt_d = '0;
              if (accel_en && (lvl_q < LVL_TOP)) lvl_d = lvl_q + 1'b1;
            end else begin
              cnt_d = cnt_inc[CNT_W-1:0];
            end
            // Reload already reflects any level change made at this step.
            ctr_d = reload_val(div_eff, lvl_d);
          end
        end
      endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
      if (!Reset_n) begin
        state_q <= IDLE;
        ctr_q   <= '0;
        lvl_q   <= '0;
        cnt_q   <= '0;
        pos_q   <= 2'd0;
        dir_q   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        ctr_q   <= ctr_d;
        lvl_q   <= lvl_d;
        cnt_q   <= cnt_d;
        pos_q   <= pos_d;
        dir_q   <= dir_d;
        pulse_q <= pulse_d;
      end
    end
  end

endmodule

// File: tb/tb_joy2quad_multi.sv
// tb/tb_joy2quad_multi.sv - scoreboard bench for joy2quad_multi with behavioural timing model
module tb_joy2quad_multi;

  localparam int CH    = 2;
  localparam int DW    = 16;
  localparam int AS    = 2;
  localparam int AMAX  = 2;

  logic            CLK = 1'b0;
  logic            Reset_n;
  logic [DW-1:0]   clkdiv;
  logic            accel_en;
  logic [CH-1:0]   right;
  logic [CH-1:0]   left;
  logic [2*CH-1:0] steer;
  logic [CH-1:0]   step_pulse;
  logic [CH-1:0]   dir;

  joy2quad_multi #(
    .CHANNELS(CH), .DIV_W(DW), .ACCEL_STEPS(AS), .ACCEL_MAX(AMAX)
  ) dut (
    .CLK(CLK), .Reset_n(Reset_n), .clkdiv(clkdiv), .accel_en(accel_en),
    .right(right), .left(left), .steer(steer), .step_pulse(step_pulse), .dir(dir)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2*CH-1:0] steer;
    logic [CH-1:0]   pulse;
    logic [CH-1:0]   dir;
    int              edge_no;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   edge_k = 0;
  bit   drv_done = 1'b0;

  // Behavioural model: absolute time of next step instead of a countdown.
  int m_act[CH];
  int m_dir[CH];
  int m_pos[CH];
  int m_lvl[CH];
  int m_cnt[CH];
  int m_next[CH];
  bit m_pulse[CH];

  function automatic int period(int lvl);
    int e;
    e = (clkdiv == 0) ? 1 : int'(clkdiv);
    e = e >> lvl;
    return (e < 1) ? 1 : e;
  endfunction

  function automatic logic [1:0] ab_of(int p);
    case (p)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_edge();
    exp_t e;
    int   req;
    for (int c = 0; c < CH; c++) begin
      m_pulse[c] = 1'b0;
      if (!Reset_n) begin
        m_act[c] = 0; m_pos[c] = 0; m_dir[c] = 0; m_lvl[c] = 0; m_cnt[c] = 0;
        continue;
      end
      req = (right[c] && !left[c]) ? 1 : ((left[c] && !right[c]) ? -1 : 0);
      if (req == 0) begin
        m_act[c] = 0;
        m_lvl[c] = 0;
      end else if (m_act[c] == 0 || ((req == 1) != (m_dir[c] == 1))) begin
        m_pos[c] = (m_pos[c] + req + 4) % 4;
        m_dir[c] = (req == 1) ? 1 : 0;
        m_pulse[c] = 1'b1;
        m_act[c] = 1;
        m_lvl[c] = 0;
        m_cnt[c] = 1;
        m_next[c] = edge_k + period(0);
      end else if (edge_k == m_next[c]) begin
        m_pos[c] = (m_pos[c] + req + 4) % 4;
        m_pulse[c] = 1'b1;
        m_cnt[c]++;
        if (m_cnt[c] >= AS) begin
          if (accel_en && m_lvl[c] < AMAX) m_lvl[c]++;
          m_cnt[c] = 0;
        end
        if (!accel_en) m_lvl[c] = 0;
        m_next[c] = edge_k + period(m_lvl[c]);
      end else if (!accel_en) begin
        m_lvl[c] = 0;
      end
    end
    for (int c = 0; c < CH; c++) begin
      e.steer[2*c +: 2] = ab_of(m_pos[c]);
      e.pulse[c] = m_pulse[c];
      e.dir[c]   = m_dir[c][0];
    end
    e.edge_no = edge_k;
    sbq.push_back(e);
    edge_k++;
  endtask

  task automatic run_cycles(input int n);
    for (int j = 0; j < n; j++) begin
      model_edge();
      @(negedge CLK);
    end
  endtask

  // Monitor: compare each edge's outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        total++;
        if (steer !== e.steer || step_pulse !== e.pulse || dir !== e.dir) begin
          bad++;
          $display("FAIL out edge=%0d steer got=%b exp=%b pulse got=%b exp=%b dir got=%b exp=%b",
                   e.edge_no, steer, e.steer, step_pulse, e.pulse, dir, e.dir);
        end
      end else if (!drv_done) begin
        total++;
        bad++;
        $display("FAIL sbq_empty edge=%0d got=empty exp=entry", edge_k);
      end
    end
  end

  initial begin
    Reset_n = 1'b0; right = '1; left = '0; clkdiv = 16'd4; accel_en = 1'b0;
    // Reset held with requests active.
    run_cycles(3);
    // Fixed rate, clkdiv=4, channel 0 right.
    Reset_n = 1'b1; right = 2'b01;
    run_cycles(20);
    right = 2'b00;
    run_cycles(2);
    // Acceleration on left, then drop accel_en mid-run.
    clkdiv = 16'd16; accel_en = 1'b1; left = 2'b01;
    run_cycles(60);
    accel_en = 1'b0;
    run_cycles(40);
    accel_en = 1'b1;
    // Conflict, release to idle mid-run, re-press.
    right = 2'b01; left = 2'b01;
    run_cycles(30);
    right = 2'b00;
    run_cycles(10);
    left = 2'b00;
    run_cycles(5);
    left = 2'b01;
    run_cycles(20);
    // Reach level 2 going right, then reverse.
    left = 2'b00; right = 2'b01;
    run_cycles(60);
    right = 2'b00; left = 2'b01;
    run_cycles(30);
    // clkdiv=0 on channel 1, reset mid-run.
    left = 2'b00; right = 2'b10; clkdiv = 16'd0;
    run_cycles(10);
    Reset_n = 1'b0;
    run_cycles(2);
    Reset_n = 1'b1;
    run_cycles(5);
    // Randomized mix.
    for (int j = 0; j < 800; j++) begin
      if ($urandom_range(0, 9) == 0) right = CH'($urandom);
      if ($urandom_range(0, 14) == 0) left = CH'($urandom);
      if ($urandom_range(0, 49) == 0) clkdiv = DW'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) accel_en = ~accel_en;
      Reset_n = ($urandom_range(0, 299) != 0);
      run_cycles(1);
    end
    drv_done = 1'b1;
    for (int j = 0; j < 10 && sbq.size() > 0; j++) @(posedge CLK);
    #2;
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d exp=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
